array_20_ctrl: RTL
==================

ARRAY_20_CTRL -- requirements
Module: array_20_ctrl

Interface
REQ-001 SHALL have parameters: DEPTH, default 32, number of words; AW, default 5, address width; DW, default 516, data width; MSEG, default 2, write-mask segments of DW/MSEG = 258 bits each.
REQ-002 SHALL have port: clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high.
REQ-004 SHALL have ports: req_valid input 1, req_ready output 1, req_write input 1 (1 = write, 0 = read), req_addr input AW, req_mask input MSEG, req_data input DW.
REQ-005 SHALL have ports: resp_valid output 1, resp_ready input 1, resp_data output DW, read data in request order.
REQ-006 SHALL have port: busy  output  1  init sweep in progress.
REQ-007 SHALL have SRAM-side ports: RW0_addr output AW, RW0_en output 1, RW0_wmode output 1, RW0_wmask output MSEG, RW0_wdata output DW, RW0_rdata input DW; SRAM returns read data one cycle after RW0_en && !RW0_wmode.

Function
REQ-008 SHALL accept a request only on req_valid && req_ready ("accept").
REQ-009 SHALL drive the SRAM combinationally in the accept cycle: RW0_en=1, RW0_wmode=req_write, RW0_addr=req_addr, RW0_wmask=req_mask, RW0_wdata=req_data; RW0_en=0 in every other non-init cycle.
REQ-010 SHALL register a read-inflight flag on read accept; on the next cycle push RW0_rdata into a 2-entry response FIFO.
REQ-011 SHALL set req_ready = !busy && (fifo_count + inflight < 2), independent of req_valid and req_write.
REQ-012 SHALL present resp_valid = (fifo_count != 0) and resp_data = FIFO head; pop on resp_valid && resp_ready.
REQ-013 SHALL support push and pop in the same cycle with count unchanged and order preserved; FIFO pointers wrap modulo 2.
REQ-014 SHALL hold resp_data stable while resp_valid && !resp_ready.
REQ-015 SHALL give read latency accept-to-resp_valid of exactly 2 cycles when the FIFO is empty.
REQ-016 SHALL return, for a read accepted the cycle after a write to the same address, the newly written data on enabled segments.
REQ-017 SHALL leave the write mask semantics to the SRAM: segment i written only when req_mask[i]=1; req_mask=0 on a write is a legal no-op access.
REQ-018 SHALL never overflow the FIFO; a push while count=2 is impossible by REQ-011.

Reset
REQ-019 SHALL on reset clear FIFO count, pointers and inflight flag, discarding any in-flight read.
REQ-020 SHALL while reset is high drive resp_valid=0, req_ready=0, RW0_en=0.
REQ-021 SHALL on reset during an init sweep restart the sweep from address 0.

Configuration
REQ-022 SHALL with ARRAY_20_CTRL_INIT_EN defined enter state INIT after reset: one write per cycle, RW0_en=1, RW0_wmode=1, RW0_wmask all ones, RW0_wdata=0, address 0 to DEPTH-1; busy=1, req_ready=0; after address DEPTH-1 move to RUN, busy=0.
REQ-023 SHALL with ARRAY_20_CTRL_INIT_EN undefined enter RUN on the first cycle after reset deasserts, busy tied 0, no init writes.
REQ-024 SHALL with the macro defined assert busy=1 in the reset cycle; without it busy=0.

Verification
REQ-025 Init (macro on): release reset -> busy=1 for 32 cycles, RW0 writes addr 0..31 with wdata 0, mask 2'b11; cycle 33 busy=0, req_ready=1.
REQ-026 Write then read: write addr 5, mask 2'b11, data pattern A; next cycle read addr 5 -> resp_valid 2 cycles after read accept, resp_data=A.
REQ-027 Partial mask: write addr 7 all-ones data mask 2'b11, then write zeros mask 2'b01, read addr 7 -> bits 257:0 zero, bits 515:258 one.
REQ-028 Backpressure: resp_ready=0, issue reads to addr 1,2,3 back-to-back -> two accepted, req_ready=0 thereafter; raise resp_ready -> data for 1 then 2, then third read accepted.
REQ-029 Simultaneous push/pop: resp_ready=1, streaming reads every allowed cycle -> no data lost or reordered, fifo_count never exceeds 2.
REQ-030 Reset mid-operation: assert reset one cycle after a read accept -> resp_valid=0 after reset, no stale response emerges; with macro, reset at init address 12 -> sweep restarts at 0.

Source files
------------

// File: rtl/array_20_ctrl.sv
// rtl/array_20_ctrl.sv - single-port SRAM request/response controller; optional init sweep via ARRAY_20_CTRL_INIT_EN
module array_20_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 516,
  parameter int MSEG  = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [AW-1:0]   req_addr,
  input  logic [MSEG-1:0] req_mask,
  input  logic [DW-1:0]   req_data,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [DW-1:0]   resp_data,
  output logic            busy,
  output logic [AW-1:0]   RW0_addr,
  output logic            RW0_en,
  output logic            RW0_wmode,
  output logic [MSEG-1:0] RW0_wmask,
  output logic [DW-1:0]   RW0_wdata,
  input  logic [DW-1:0]   RW0_rdata
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

`ifdef ARRAY_20_CTRL_INIT_EN
  localparam state_t RESET_STATE = ST_INIT;
`else
  localparam state_t RESET_STATE = ST_RUN;
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] init_addr_q, init_addr_d;

  logic [DW-1:0] fifo_mem [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q;
  logic          inflight_q;

  logic          in_init, accept, push, pop;
  logic [2:0]    outstanding;

  // A read sits either in the SRAM pipeline (inflight) or in the FIFO; both count against the 2 slots
  assign outstanding = {1'b0, count_q} + {2'b00, inflight_q};
  assign in_init     = (state_q == ST_INIT) && !reset;
  assign req_ready   = !reset && !in_init && (outstanding < 3'd2);
  assign accept      = req_valid && req_ready;
  assign resp_valid  = !reset && (count_q != 2'd0);
  assign resp_data   = fifo_mem[rd_ptr_q];
  assign push        = inflight_q;
  assign pop         = resp_valid && resp_ready;

`ifdef ARRAY_20_CTRL_INIT_EN
  assign busy = reset || in_init;
`else
  assign busy = 1'b0;
`endif

  // State register: init sweep restarts from address 0 on every reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  // Next state: walk the sweep address, hand over to RUN after the last word
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    case (state_q)
      ST_INIT: begin
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == AW'(DEPTH - 1)) begin
          state_d     = ST_RUN;
          init_addr_d = '0;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // SRAM port mux: sweep writes zeros with full mask, otherwise pass the accepted request through
  always_comb begin
    RW0_en    = 1'b0;
    RW0_wmode = req_write;
    RW0_addr  = req_addr;
    RW0_wmask = req_mask;
    RW0_wdata = req_data;
    if (in_init) begin
      RW0_en    = 1'b1;
      RW0_wmode = 1'b1;
      RW0_addr  = init_addr_q;
      RW0_wmask = '1;
      RW0_wdata = '0;
    end else begin
      RW0_en    = accept;
    end
  end

  // Response FIFO control: inflight read lands one cycle after accept, reset drops it
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      inflight_q <= accept && !req_write;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // FIFO storage: capture SRAM read data in the cycle after the read accept
  always_ff @(posedge clock) begin
    if (!reset && push) fifo_mem[wr_ptr_q] <= RW0_rdata;
  end

endmodule
